wb_select_stage: RTL
====================

Name: wb_select_stage

Overview:
- Registered, parametrised writeback-select stage for the processor datapath. It is the successor to the 2-input combinational ALU/memory writeback mux.
- Selects one of NUM_SRC result sources (ALU, memory, PC+4, immediate, ...) and carries destination register address and write enable alongside the data.
- Outputs through a valid/ready interface backed by a 2-entry skid buffer, so the register-file write port can stall without dropping results.
- Sits between the execute/memory stage and the register file.

Parameters:
- DATA_W, 32, width of each source and of out_data
- NUM_SRC, 4, number of selectable sources (2..8)
- SEL_W, 3, width of in_sel; must satisfy 2**SEL_W >= NUM_SRC
- RD_W, 5, destination register address width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- in_sel  input  SEL_W  source index
- in_data  input  NUM_SRC*DATA_W  packed sources; source k occupies bits [k*DATA_W +: DATA_W]
- in_rd  input  RD_W  destination register
- in_we  input  1  register write enable
- in_ld_size  input  2  load size: 0=byte, 1=half, 2=word
- in_ld_uns  input  1  zero-extend load
- in_byte_off  input  2  address bits [1:0] of the load
- out_valid  output  1  result valid
- out_ready  input  1  register file accepts result
- out_data  output  DATA_W  selected result
- out_rd  output  RD_W  destination register
- out_we  output  1  write enable; qualified by out_valid
- out_err  output  1  beat carried an out-of-range in_sel

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low, asynchronously: out_valid=0, out_data=0, out_rd=0, out_we=0, out_err=0, skid entry empty, in_ready=1.
- Handshake:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - in_ready is registered and equals "skid empty". It has no combinational path from out_ready.
- Selection:
  - sel_data = source[in_sel].
  - If in_sel >= NUM_SRC: sel_data = 0, out_we is forced to 0 for that beat, and out_err=1 travels with the beat.
- Datapath:
  - Accepted beat with the output register empty, or with the output register consumed in the same cycle: load the output register. Latency is 1 cycle.
  - Accepted beat while the output register is held (out_valid=1, out_ready=0): store in the skid entry; in_ready drops the next cycle.
  - Output consumed while skid is full: skid moves to the output register and in_ready returns high the next cycle.
  - Order is always preserved. Sustained throughput is 1 beat/cycle when out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, all out_* signals hold stable.
- Simultaneous events: consume and accept in the same cycle with skid empty loads the new beat directly; there is no bubble.
- in_valid=0: no state change except draining.
- Reset mid-operation: all buffered beats are discarded; no partial write appears after reset.

Optional Feature:
- Macro: WB_LOAD_ALIGN_EN.
- Defined:
  - When in_sel==SRC_MEM, memory data is shifted right by 8*in_byte_off.
  - Then truncated to the width given by in_ld_size: byte 8, half 16, word 32.
  - Then sign-extended, or zero-extended if in_ld_uns=1.
  - Half with in_byte_off odd, or word with in_byte_off!=0, sets out_err=1 and forces out_we=0.
  - in_ld_size=3 is treated as word.
- Undefined: in_ld_size, in_ld_uns and in_byte_off are ignored and memory data passes unchanged. Ports remain present.

Decomposition:
- Package wb_pkg holds:
  - source index constants: SRC_ALU=0, SRC_MEM=1, SRC_PC4=2, SRC_IMM=3
  - load size constants: LD_B=0, LD_H=1, LD_W=2
  - a packed beat struct {data, rd, we, err}
- Sub-module wb_skid_buffer: a generic 2-entry valid/ready skid buffer parametrised on payload width. wb_select_stage instantiates it after the combinational select/align logic.

Test Plan:
- Reset then in_sel=1, MEM=0x1234_5678, rd=5, we=1, out_ready=1 -> next cycle out_valid=1, out_data=0x1234_5678, out_rd=5, out_we=1, out_err=0.
- Back-to-back 8 beats, in_sel cycling 0..3, out_ready=1 -> 8 outputs on 8 consecutive cycles, correct order, in_ready stays 1.
- out_ready=0 with two beats sent (A then B) -> A held on outputs, B in skid, in_ready=0. Then out_ready=1 -> A, then B on the next cycle; in_ready=1 one cycle after the skid empties.
- in_sel=5 with NUM_SRC=4, we=1 -> out_data=0, out_we=0, out_err=1.
- With WB_LOAD_ALIGN_EN: MEM=0x80FF_7F01, size=byte, off=2, uns=0 -> 0xFFFF_FFFF. Same with uns=1 -> 0x0000_00FF. size=half, off=1 -> out_err=1, out_we=0.
- Assert rst_n low asynchronously while the skid is full and out_ready=0 -> out_valid=0 immediately; in_ready=1 after release; no stale beat emitted.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and beat layout for the writeback-select stage.
package wb_pkg;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_IMM = 3;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;

  localparam int WB_DATA_W = 32;
  localparam int WB_RD_W   = 5;

  // Field order matches the payload packing used by wb_select_stage.
  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_RD_W-1:0]   rd;
    logic                 we;
    logic                 err;
  } wb_beat_t;

endpackage

// File: rtl/wb_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one skid
// entry. in_ready is driven purely from registered state.
module wb_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);

  logic             outValid_q, outValid_d;
  logic             skidValid_q, skidValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic             accept;
  logic             outFree;

  assign accept  = in_valid & ~skidValid_q;
  assign outFree = ~outValid_q | out_ready;

  // The skid entry always drains before a new beat can reach the output,
  // which keeps beats in order.
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    if (outFree) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outData_d   = skidData_q;
        skidValid_d = 1'b0;
      end else if (accept) begin
        outValid_d = 1'b1;
        outData_d  = in_payload;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidData_d  = in_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
    end
  end

  assign in_ready    = ~skidValid_q;
  assign out_valid   = outValid_q;
  assign out_payload = outData_q;

endmodule

// File: rtl/wb_select_stage.sv
// Registered writeback-select stage: picks one result source, optionally
// aligns loads (macro WB_LOAD_ALIGN_EN), and buffers the beat in a skid buffer.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 3,
  parameter int RD_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]           in_rd,
  input  logic                      in_we,
  input  logic [1:0]                in_ld_size,
  input  logic                      in_ld_uns,
  input  logic [1:0]                in_byte_off,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [RD_W-1:0]           out_rd,
  output logic                      out_we,
  output logic                      out_err
);

  localparam int PAYLOAD_W = DATA_W + RD_W + 2;

  logic [DATA_W-1:0]    selData;
  logic [DATA_W-1:0]    alignData;
  logic                 selErr;
  logic                 alignErr;
  logic                 beatErr;
  logic [PAYLOAD_W-1:0] inPayload;
  logic [PAYLOAD_W-1:0] outPayload;

  // An index with no matching source leaves the data zero and flags the beat.
  always_comb begin
    selData = '0;
    selErr  = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        selData = in_data[k*DATA_W +: DATA_W];
        selErr  = 1'b0;
      end
    end
  end

`ifdef WB_LOAD_ALIGN_EN
  logic [DATA_W-1:0] memShift;

  assign memShift = selData >> {in_byte_off, 3'b000};

  // Word loads (and the reserved size 3) take the full shifted word.
  always_comb begin
    alignData = selData;
    alignErr  = 1'b0;
    if (in_sel == SEL_W'(SRC_MEM)) begin
      case (in_ld_size)
        LD_B: begin
          alignData = {{(DATA_W-8){memShift[7] & ~in_ld_uns}}, memShift[7:0]};
        end
        LD_H: begin
          alignData = {{(DATA_W-16){memShift[15] & ~in_ld_uns}}, memShift[15:0]};
          alignErr  = in_byte_off[0];
        end
        default: begin
          alignData = memShift;
          alignErr  = (in_byte_off != 2'd0);
        end
      endcase
    end
  end
`else
  logic unusedLoadCtrl;

  assign unusedLoadCtrl = ^{in_ld_size, in_ld_uns, in_byte_off};
  assign alignData      = selData;
  assign alignErr       = 1'b0;
`endif

  assign beatErr   = selErr | alignErr;
  assign inPayload = {alignData, in_rd, in_we & ~beatErr, beatErr};

  wb_skid_buffer #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (inPayload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(outPayload)
  );

  assign {out_data, out_rd, out_we, out_err} = outPayload;

endmodule
